vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Upstream raster timing stage for the TinyVGA PMOD output path. It generates 640x480@60 VGA sync pulses, the display-active flag, and the current pixel coordinates. It also provides per-line and per-frame strobes and a frame counter. The downstream pixel-colour stage consumes these outputs directly, and animation logic advances on frame_start.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_NEG, 1, 1 = sync active-low, 0 = active-high
FRAME_W, 10, frame_count width

Ports:
clk  input  1  pixel clock (nominal 25.175 MHz)
rst_n  input  1  synchronous active-low reset
pix_en  input  1  pixel advance enable; tie high for full-rate operation
hsync  output  1  horizontal sync, polarity per SYNC_NEG
vsync  output  1  vertical sync, polarity per SYNC_NEG
display_on  output  1  high while (hpos,vpos) is inside the visible area
hpos  output  10  current column, 0..H_TOTAL-1
vpos  output  10  current line, 0..V_TOTAL-1
line_start  output  1  one-cycle strobe when hpos becomes 0
frame_start  output  1  one-cycle strobe when (hpos,vpos) becomes (0,0)
frame_count  output  FRAME_W  completed-frame counter, wraps modulo 2^FRAME_W

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525). Both must be <= 1024; otherwise elaboration fails.
- All outputs are registered. hsync, vsync, display_on and the strobes are decoded from the next counter value, so they always describe the hpos/vpos presented in the same cycle. There is zero-cycle skew between coordinates and flags.
- Reset: at any posedge with rst_n=0:
  - hpos = H_TOTAL-1 (799), vpos = V_TOTAL-1 (524);
  - hsync and vsync at their inactive level (1 when SYNC_NEG=1);
  - display_on = 0, line_start = 0, frame_start = 0, frame_count = 0.
  - Reset mid-frame behaves identically; no partial state survives.
- Advance: on a posedge with rst_n=1 and pix_en=1, hpos increments. At hpos = H_TOTAL-1 it wraps to 0 and vpos increments. At vpos = V_TOTAL-1 with an hpos wrap, vpos also wraps to 0.
- The first enabled posedge after reset therefore presents (0,0) with display_on=1, line_start=1 and frame_start=1.
- pix_en=0: all counters and level outputs hold their values; line_start and frame_start are forced to 0. A strobe lasts exactly one enabled pixel and is never re-issued while stalled.
- hsync is active for H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
- vsync is active for V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491), for entire lines including the porches.
- display_on = (hpos < H_DISPLAY) and (vpos < V_DISPLAY).
- frame_count increments by 1 in the same cycle frame_start asserts. It wraps from 2^FRAME_W-1 to 0, and is not incremented for the (0,0) reached directly out of reset.
- Counters never take values >= H_TOTAL or >= V_TOTAL.

Test Plan:
- Reset held 3 cycles, then released with pix_en=1 -> during reset hpos=799, vpos=524, hsync=vsync=1, display_on=0. First cycle after release: hpos=0, vpos=0, display_on=1, frame_start=1, frame_count=0.
- Run one line -> hsync low for exactly 96 consecutive cycles starting at hpos=656. display_on falls at hpos=640. At 799->0, vpos goes 0->1 and line_start pulses once.
- Run full frames -> 420000 cycles between frame_start pulses. vsync is low for exactly 1600 cycles (vpos 490..491). frame_count reads 1 and 2 at successive frame_start pulses.
- Toggle pix_en 1/0 alternately -> hpos advances every other cycle. line_start and frame_start stay single-cycle and do not repeat during stalls. Frame period doubles to 840000 cycles.
- Assert rst_n=0 at (hpos=300, vpos=200) for 1 cycle -> next cycle shows (799,524) with syncs inactive and frame_count=0. After release, (0,0) follows.
- Preload frame_count to 1023 via a forced run of 1023 frames (or with FRAME_W=2 over 4 frames) -> counter wraps to 0 on the following frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for the TinyVGA PMOD output path (640x480@60 with
// the default parameters). It produces horizontal/vertical sync, the
// display-active flag, the current pixel coordinates, per-line and per-frame
// strobes, and a completed-frame counter.
//
// Every output is a register. The flags are decoded from the counter value
// being loaded on the same edge, so flags and coordinates are never skewed.
//
// Ports:
//   clk          in   pixel clock (nominal 25.175 MHz)
//   rst_n        in   synchronous active-low reset
//   pix_en       in   pixel advance enable (tie high for full rate)
//   hsync        out  horizontal sync, polarity set by SYNC_NEG
//   vsync        out  vertical sync, polarity set by SYNC_NEG
//   display_on   out  high while (hpos,vpos) lies in the visible area
//   hpos         out  current column, 0..H_TOTAL-1
//   vpos         out  current line, 0..V_TOTAL-1
//   line_start   out  one-pixel strobe when hpos becomes 0
//   frame_start  out  one-pixel strobe when (hpos,vpos) becomes (0,0)
//   frame_count  out  completed-frame counter, wraps modulo 2^FRAME_W
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_NEG  = 1,
  parameter int FRAME_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode boundaries are 11 bits wide so an end boundary of exactly 1024
  // is still representable.
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] HS_BEGIN = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] VS_BEGIN = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  // Sync output = active flag XOR this; it is also the inactive level.
  localparam logic SYNC_INV = (SYNC_NEG != 0);

  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       h_wrap;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       de_nxt;
  logic       ls_nxt;
  logic       fs_nxt;

  // Set by reset, cleared by the first advance: the (0,0) reached straight
  // out of reset raises frame_start but is not a completed frame.
  logic       first_frame;

  always_comb begin
    h_wrap = (hpos == H_LAST);
    h_nxt  = h_wrap ? 10'd0 : hpos + 10'd1;
    v_nxt  = vpos;
    if (h_wrap) begin
      v_nxt = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    end
    hs_nxt = ({1'b0, h_nxt} >= HS_BEGIN) && ({1'b0, h_nxt} < HS_END);
    vs_nxt = ({1'b0, v_nxt} >= VS_BEGIN) && ({1'b0, v_nxt} < VS_END);
    de_nxt = ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
    ls_nxt = (h_nxt == 10'd0);
    fs_nxt = ls_nxt && (v_nxt == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      hsync       <= SYNC_INV;
      vsync       <= SYNC_INV;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      first_frame <= 1'b1;
    end else if (pix_en) begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      hsync       <= hs_nxt ^ SYNC_INV;
      vsync       <= vs_nxt ^ SYNC_INV;
      display_on  <= de_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
      first_frame <= 1'b0;
      if (fs_nxt && !first_frame) begin
        frame_count <= frame_count + 1'b1;
      end
    end else begin
      // Stalled: coordinates and levels hold, strobes must not repeat.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share one clock: "a" uses the default 640x480 timing with
// active-low sync, "b" uses a tiny raster (15x9, active-high sync,
// FRAME_W=2) so whole frames and frame_count wrap fit in a short run.
// A behavioural model predicts each instance's outputs; the prediction is
// queued when the inputs are driven and compared after the clock edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VD = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
  localparam int A_HT = A_HD + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VD + A_VF + A_VS + A_VB;

  localparam int B_HD = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VD = 4, B_VF = 2, B_VS = 2, B_VB = 1;
  localparam int B_HT = B_HD + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VD + B_VF + B_VS + B_VB;
  localparam int B_FW = 2;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [9:0] fc;
  } out_t;

  typedef struct {
    int h;
    int v;
    int fc;
    bit fr;
    bit ls;
    bit fs;
  } mstate_t;

  typedef struct {
    bit   rst_n;
    bit   en;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra, ea, rb, eb;

  logic            hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0]      h_a, v_a, fc_a;
  logic            hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0]      h_b, v_b;
  logic [B_FW-1:0] fc_b;

  vga_timing_gen u_a (
    .clk(clk), .rst_n(ra), .pix_en(ea),
    .hsync(hs_a), .vsync(vs_a), .display_on(de_a),
    .hpos(h_a), .vpos(v_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .SYNC_NEG(0), .FRAME_W(B_FW)
  ) u_b (
    .clk(clk), .rst_n(rb), .pix_en(eb),
    .hsync(hs_b), .vsync(vs_b), .display_on(de_b),
    .hpos(h_b), .vpos(v_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  int      n_chk  = 0;
  int      n_pass = 0;
  int      cyc    = 0;
  mstate_t ma, mb;
  out_t    qa[$];
  out_t    qb[$];
  vec_t    vt[8];

  function automatic mstate_t mnext(mstate_t s, bit rst_n, bit en, int ht, int vt_, int fmod);
    mstate_t n = s;
    if (!rst_n) begin
      n.h = ht - 1; n.v = vt_ - 1; n.fc = 0; n.fr = 1'b1; n.ls = 1'b0; n.fs = 1'b0;
    end else if (en) begin
      n.h = s.h + 1;
      if (n.h == ht) begin
        n.h = 0;
        n.v = s.v + 1;
        if (n.v == vt_) n.v = 0;
      end
      n.ls = (n.h == 0);
      n.fs = n.ls && (n.v == 0);
      if (n.fs && !s.fr) n.fc = (s.fc + 1) % fmod;
      n.fr = 1'b0;
    end else begin
      n.ls = 1'b0; n.fs = 1'b0;
    end
    return n;
  endfunction

  function automatic out_t mout(mstate_t s, int hd, int hf, int hsw, int vd, int vf, int vsw, bit neg);
    out_t o;
    o.h  = 10'(s.h);
    o.v  = 10'(s.v);
    o.hs = ((s.h >= hd + hf) && (s.h < hd + hf + hsw)) ^ neg;
    o.vs = ((s.v >= vd + vf) && (s.v < vd + vf + vsw)) ^ neg;
    o.de = (s.h < hd) && (s.v < vd);
    o.ls = s.ls;
    o.fs = s.fs;
    o.fc = 10'(s.fc);
    return o;
  endfunction

  function automatic out_t mk(int h, int v, bit hs, bit vs, bit de, bit ls, bit fs, int fc);
    out_t o;
    o.h = 10'(h); o.v = 10'(v); o.hs = hs; o.vs = vs; o.de = de;
    o.ls = ls; o.fs = fs; o.fc = 10'(fc);
    return o;
  endfunction

  function automatic out_t dut_a();
    out_t o;
    o.h = h_a; o.v = v_a; o.hs = hs_a; o.vs = vs_a; o.de = de_a;
    o.ls = ls_a; o.fs = fs_a; o.fc = fc_a;
    return o;
  endfunction

  function automatic out_t dut_b();
    out_t o;
    o.h = h_b; o.v = v_b; o.hs = hs_b; o.vs = vs_b; o.de = de_b;
    o.ls = ls_b; o.fs = fs_b; o.fc = {8'd0, fc_b};
    return o;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                     o.h, o.v, o.hs, o.vs, o.de, o.ls, o.fs, o.fc);
  endfunction

  task automatic check_out(string name, out_t act, out_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: actual {%s} required {%s}", name, cyc, fmt(act), fmt(exp));
  endtask

  task automatic check_int(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d: actual %0d required %0d", name, cyc, act, exp);
  endtask

  // One clock: predict both instances, let the edge happen, compare.
  task automatic tick();
    ma = mnext(ma, ra, ea, A_HT, A_VT, 1024);
    qa.push_back(mout(ma, A_HD, A_HF, A_HS, A_VD, A_VF, A_VS, 1'b1));
    mb = mnext(mb, rb, eb, B_HT, B_VT, 1 << B_FW);
    qb.push_back(mout(mb, B_HD, B_HF, B_HS, B_VD, B_VF, B_VS, 1'b0));
    @(posedge clk);
    #1;
    cyc++;
    check_out("sb_a", dut_a(), qa.pop_front());
    check_out("sb_b", dut_b(), qb.pop_front());
  endtask

  task automatic set_vec(int i, bit r, bit e, out_t exp);
    vt[i].rst_n = r;
    vt[i].en    = e;
    vt[i].exp   = exp;
  endtask

  initial begin
    bit prev_hs, prev_de, prev_ls_b, prev_fs_b, hs_done, de_fall_seen, found;
    int prev_h, hs_run, ls_cnt, b_last_fs, b_vs_cnt, b_nfs, b_periods, h0, v0, k;

    ma = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
    mb = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
    ra = 1'b0; ea = 1'b1; rb = 1'b0; eb = 1'b1;

    // Reset, release, stall, advance on the default-timing instance.
    set_vec(0, 1'b0, 1'b1, mk(799, 524, 1, 1, 0, 0, 0, 0));
    set_vec(1, 1'b0, 1'b0, mk(799, 524, 1, 1, 0, 0, 0, 0));
    set_vec(2, 1'b0, 1'b1, mk(799, 524, 1, 1, 0, 0, 0, 0));
    set_vec(3, 1'b1, 1'b1, mk(0,   0,   1, 1, 1, 1, 1, 0));
    set_vec(4, 1'b1, 1'b0, mk(0,   0,   1, 1, 1, 0, 0, 0));
    set_vec(5, 1'b1, 1'b0, mk(0,   0,   1, 1, 1, 0, 0, 0));
    set_vec(6, 1'b1, 1'b1, mk(1,   0,   1, 1, 1, 0, 0, 0));
    set_vec(7, 1'b1, 1'b1, mk(2,   0,   1, 1, 1, 0, 0, 0));

    for (int i = 0; i < 8; i++) begin
      ra = vt[i].rst_n; ea = vt[i].en;
      rb = vt[i].rst_n; eb = vt[i].en;
      tick();
      check_out($sformatf("vec%0d", i), dut_a(), vt[i].exp);
    end

    // Full-rate run: one line of "a", several frames of "b".
    ra = 1'b1; ea = 1'b1; rb = 1'b1; eb = 1'b1;
    prev_hs = hs_a; prev_de = de_a; prev_h = int'(h_a);
    hs_run = 0; ls_cnt = 0; hs_done = 1'b0; de_fall_seen = 1'b0;
    b_last_fs = -1; b_vs_cnt = 0; b_nfs = 0; b_periods = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (prev_hs && !hs_a) begin
        check_int("hsync_start_hpos", int'(h_a), 656);
        hs_run = 0;
      end
      if (!hs_a) hs_run++;
      if (!prev_hs && hs_a && !hs_done) begin
        check_int("hsync_width", hs_run, 96);
        hs_done = 1'b1;
      end
      if (prev_de && !de_a && !de_fall_seen) begin
        check_int("de_fall_hpos", int'(h_a), 640);
        de_fall_seen = 1'b1;
      end
      if (ls_a) begin
        ls_cnt++;
        check_int("ls_prev_hpos", prev_h, 799);
        check_int("ls_vpos", int'(v_a), 1);
      end
      prev_hs = hs_a; prev_de = de_a; prev_h = int'(h_a);
      if (vs_b) b_vs_cnt++;
      if (fs_b) begin
        b_nfs++;
        check_int("b_frame_count", int'(fc_b), b_nfs % 4);
        if (b_last_fs >= 0) begin
          check_int("b_frame_period", cyc - b_last_fs, B_HT * B_VT);
          check_int("b_vsync_cycles", b_vs_cnt, B_VS * B_HT);
        end
        b_last_fs = cyc; b_vs_cnt = 0;
      end
    end
    check_int("a_line_start_count", ls_cnt, 1);
    check_int("a_hsync_seen", int'(hs_done), 1);
    check_int("a_de_fall_seen", int'(de_fall_seen), 1);
    check_int("b_frame_starts", b_nfs, 7);

    // pix_en alternating 1/0: half rate, strobes stay single-cycle.
    h0 = int'(h_a); v0 = int'(v_a);
    b_last_fs = -1; prev_ls_b = ls_b; prev_fs_b = fs_b;
    for (int i = 0; i < 600; i++) begin
      ea = (i % 2 == 0); eb = (i % 2 == 0);
      tick();
      if (ls_b) check_int("b_ls_single", int'(prev_ls_b), 0);
      if (fs_b) begin
        check_int("b_fs_single", int'(prev_fs_b), 0);
        b_nfs++;
        check_int("b_frame_count_stall", int'(fc_b), b_nfs % 4);
        if (b_last_fs >= 0) begin
          check_int("b_frame_period_half", cyc - b_last_fs, 2 * B_HT * B_VT);
          b_periods++;
        end
        b_last_fs = cyc;
      end
      prev_ls_b = ls_b; prev_fs_b = fs_b;
    end
    check_int("b_half_rate_periods", b_periods, 1);
    check_int("a_half_rate_hpos", int'(h_a), (h0 + 300) % A_HT);
    check_int("a_half_rate_vpos", int'(v_a), v0);

    // Mid-frame reset on "b" at (5,3).
    ea = 1'b1; eb = 1'b1;
    found = 1'b0;
    for (k = 0; k < 200 && !found; k++) begin
      if (h_b == 10'd5 && v_b == 10'd3) found = 1'b1;
      else tick();
    end
    check_int("b_reach_5_3", int'(found), 1);
    rb = 1'b0;
    tick();
    check_out("b_mid_reset", dut_b(), mk(B_HT - 1, B_VT - 1, 0, 0, 0, 0, 0, 0));
    rb = 1'b1;
    tick();
    check_out("b_reset_release", dut_b(), mk(0, 0, 0, 0, 1, 1, 1, 0));
    b_last_fs = cyc; found = 1'b0;
    for (k = 0; k < 300 && !found; k++) begin
      tick();
      if (fs_b) found = 1'b1;
    end
    check_int("b_fs_after_reset_seen", int'(found), 1);
    check_int("b_period_after_reset", cyc - b_last_fs, B_HT * B_VT);
    check_int("b_fc_after_reset", int'(fc_b), 1);

    // Mid-line reset on "a" at hpos=300.
    found = 1'b0;
    for (k = 0; k < 900 && !found; k++) begin
      if (h_a == 10'd300) found = 1'b1;
      else tick();
    end
    check_int("a_reach_300", int'(found), 1);
    ra = 1'b0;
    tick();
    check_out("a_mid_reset", dut_a(), mk(799, 524, 1, 1, 0, 0, 0, 0));
    ra = 1'b1;
    tick();
    check_out("a_reset_release", dut_a(), mk(0, 0, 1, 1, 1, 1, 1, 0));
    tick();
    check_out("a_after_release", dut_a(), mk(1, 0, 1, 1, 1, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
